// File: rtl/dadda_pkg.sv
// Shared constants and elaboration-time helpers for the Dadda multiplier.
// The reduction plan is computed here so the tree wiring can be generated from it.
package dadda_pkg;

   localparam int DADDA_HEIGHTS [8] = '{2, 3, 4, 6, 9, 13, 19, 28};
   localparam int LATENCY [2] = '{2, 3};

   function automatic int dadda_stage_count(input int w);
      int n;
      n = 0;
      for (int k = 0; k < 8; k++)
         if (DADDA_HEIGHTS[k] < w) n++;
      return n;
   endfunction

   // Column height of the initial matrix, including the signed-mode constant slots
   function automatic int dadda_init_height(input int w, input int c);
      int lo, hi, h;
      lo = (c > w - 1) ? c - (w - 1) : 0;
      hi = (c < w - 1) ? c : w - 1;
      h  = (c <= 2 * w - 2) ? hi - lo + 1 : 0;
      if (c == w || c == 2 * w - 1) h++;
      return h;
   endfunction

   // sel 0: column height entering stage s, 1: full adders, 2: half adders
   function automatic int dadda_plan(input int w, input int s, input int c, input int sel);
      int h  [64];
      int nf [64];
      int nh [64];
      int n, d, e, cin, res;
      res = 0;
      if (c >= 0 && c < 2 * w) begin
         n = dadda_stage_count(w);
         for (int col = 0; col < 2 * w; col++) h[col] = dadda_init_height(w, col);
         for (int st = 0; st <= s; st++) begin
            d   = DADDA_HEIGHTS[n - 1 - st];
            cin = 0;
            for (int col = 0; col < 2 * w; col++) begin
               e       = h[col] + cin - d;
               nf[col] = (e > 0) ? e / 2 : 0;
               nh[col] = (e > 0) ? e % 2 : 0;
               cin     = nf[col] + nh[col];
            end
            if (st == s)
               res = (sel == 0) ? h[c] : (sel == 1) ? nf[c] : nh[c];
            for (int col = 0; col < 2 * w; col++)
               h[col] = h[col] - 2 * nf[col] - nh[col] +
                        ((col > 0) ? nf[col - 1] + nh[col - 1] : 0);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dadda_reduce.sv
// Combinational Dadda column reduction of a Baugh-Wooley partial-product matrix
// down to two rows. pp[i][j] = a[j] & b[i], weight i+j.
module dadda_reduce
   import dadda_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]   pp [WIDTH],
   input  logic               is_signed,
   output logic [2*WIDTH-1:0] row0,
   output logic [2*WIDTH-1:0] row1
);

   localparam int NS = dadda_stage_count(WIDTH);
   localparam int CW = 2 * WIDTH;

   logic lvl [NS+1][CW][WIDTH];

   for (genvar c = 0; c < CW; c++) begin : g_init
      localparam int LO  = (c > WIDTH - 1) ? c - (WIDTH - 1) : 0;
      localparam int HI  = (c < WIDTH - 1) ? c : WIDTH - 1;
      localparam int CNT = (c <= CW - 2) ? HI - LO + 1 : 0;
      for (genvar r = 0; r < WIDTH; r++) begin : g_row
         if (r < CNT) begin : g_pp
            localparam int I = LO + r;
            localparam int J = c - I;
            // MSB row/column terms are inverted in signed mode, except the MSB*MSB term
            if ((I == WIDTH - 1) != (J == WIDTH - 1)) begin : g_inv
               assign lvl[0][c][r] = pp[I][J] ^ is_signed;
            end else begin : g_plain
               assign lvl[0][c][r] = pp[I][J];
            end
         end else if (r == CNT && (c == WIDTH || c == CW - 1)) begin : g_one
            assign lvl[0][c][r] = is_signed;
         end else begin : g_zero
            assign lvl[0][c][r] = 1'b0;
         end
      end
   end

   for (genvar s = 0; s < NS; s++) begin : g_stage
      for (genvar c = 0; c < CW; c++) begin : g_col
         localparam int H  = dadda_plan(WIDTH, s, c, 0);
         localparam int F  = dadda_plan(WIDTH, s, c, 1);
         localparam int A  = dadda_plan(WIDTH, s, c, 2);
         localparam int FP = dadda_plan(WIDTH, s, c - 1, 1);
         localparam int AP = dadda_plan(WIDTH, s, c - 1, 2);
         localparam int P  = H - 3 * F - 2 * A;
         // output order: untouched bits, FA sums, HA sums, carries from column c-1
         for (genvar r = 0; r < WIDTH; r++) begin : g_row
            if (r < P) begin : g_pass
               assign lvl[s+1][c][r] = lvl[s][c][3*F+2*A+r];
            end else if (r < P + F) begin : g_fsum
               localparam int K = r - P;
               assign lvl[s+1][c][r] = lvl[s][c][3*K] ^ lvl[s][c][3*K+1] ^ lvl[s][c][3*K+2];
            end else if (r < P + F + A) begin : g_hsum
               localparam int K = r - P - F;
               assign lvl[s+1][c][r] = lvl[s][c][3*F+2*K] ^ lvl[s][c][3*F+2*K+1];
            end else if (r < P + F + A + FP) begin : g_fcy
               localparam int K = r - P - F - A;
               assign lvl[s+1][c][r] = (lvl[s][c-1][3*K]   & lvl[s][c-1][3*K+1]) |
                                       (lvl[s][c-1][3*K]   & lvl[s][c-1][3*K+2]) |
                                       (lvl[s][c-1][3*K+1] & lvl[s][c-1][3*K+2]);
            end else if (r < P + F + A + FP + AP) begin : g_hcy
               localparam int K = r - P - F - A - FP;
               assign lvl[s+1][c][r] = lvl[s][c-1][3*FP+2*K] & lvl[s][c-1][3*FP+2*K+1];
            end else begin : g_zero
               assign lvl[s+1][c][r] = 1'b0;
            end
         end
      end
   end

   for (genvar c = 0; c < CW; c++) begin : g_out
      assign row0[c] = lvl[NS][c][0];
      assign row1[c] = lvl[NS][c][1];
   end

endmodule

// File: rtl/dadda_mult_pipe.sv
// Pipelined signed/unsigned Dadda multiplier with valid/ready handshake.
// A single advance enable freezes every stage while the output is stalled.
module dadda_mult_pipe
   import dadda_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int OUT_REG = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = 2 * WIDTH;

   logic             advance;
   logic             v1;
   logic [WIDTH-1:0] a1, b1;
   logic             sg1;
   logic [WIDTH-1:0] pp [WIDTH];
   logic [CW-1:0]    row0, row1;

   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
      end else if (advance) begin
         v1  <= in_valid;
         a1  <= a;
         b1  <= b;
         sg1 <= is_signed;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_pp
      assign pp[i] = a1 & {WIDTH{b1[i]}};
   end

   dadda_reduce #(.WIDTH(WIDTH)) u_reduce (
      .pp        (pp),
      .is_signed (sg1),
      .row0      (row0),
      .row1      (row1)
   );

   if (OUT_REG != 0) begin : g_reg
      logic          v2, v3;
      logic [CW-1:0] r0_q, r1_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            v2      <= 1'b0;
            v3      <= 1'b0;
            product <= '0;
         end else if (advance) begin
            v2      <= v1;
            r0_q    <= row0;
            r1_q    <= row1;
            v3      <= v2;
            product <= r0_q + r1_q;
         end
      end

      assign out_valid = v3;
   end else begin : g_comb
      logic v2;

      always_ff @(posedge clk) begin
         if (rst) begin
            v2      <= 1'b0;
            product <= '0;
         end else if (advance) begin
            v2      <= v1;
            product <= row0 + row1;
         end
      end

      assign out_valid = v2;
   end

endmodule

// File: tb/tb_dadda_mult_pipe.sv
// Bench for dadda_mult_pipe: directed corner cases on an 8-bit registered instance,
// plus randomized streams on six width/output-register configurations.
module tb_dadda_mult_pipe;
   import dadda_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                           input logic s, input int w);
      logic [63:0] mask, xe, ye, m;
      mask = (64'd1 << w) - 64'd1;
      xe   = {32'd0, x} & mask;
      ye   = {32'd0, y} & mask;
      if (s && xe[w-1]) xe = xe | ~mask;
      if (s && ye[w-1]) ye = ye | ~mask;
      m = xe * ye;
      return m & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   // directed instance
   logic        m_rst, m_iv, m_ir, m_sg, m_ov, m_or;
   logic [7:0]  m_a, m_b;
   logic [15:0] m_p;
   logic [15:0] m_exp_q [$];
   int          m_acc_q [$];
   int          m_cyc = 0;
   int          m_got = 0;
   bit          m_lat_chk = 1'b1;

   dadda_mult_pipe #(.WIDTH(8), .OUT_REG(1)) u_dut (
      .clk       (clk),
      .rst       (m_rst),
      .in_valid  (m_iv),
      .in_ready  (m_ir),
      .a         (m_a),
      .b         (m_b),
      .is_signed (m_sg),
      .out_valid (m_ov),
      .out_ready (m_or),
      .product   (m_p)
   );

   task automatic m_cycle(input bit iv, input logic [7:0] ia, input logic [7:0] ib,
                          input bit sg, input bit ordy, input bit r,
                          input logic [15:0] exp, output bit acc);
      int ac;
      @(negedge clk);
      m_rst = r; m_iv = iv; m_a = ia; m_b = ib; m_sg = sg; m_or = ordy;
      #1;
      acc = iv && m_ir && !r;
      if (r) begin
         m_exp_q.delete();
         m_acc_q.delete();
      end
      if (acc) begin
         m_exp_q.push_back(exp);
         m_acc_q.push_back(m_cyc);
      end
      if (m_ov && ordy && !r) begin
         if (m_exp_q.size() == 0) begin
            check("m spurious out_valid", 64'(m_ov), 64'd0);
         end else begin
            ac = m_acc_q.pop_front();
            check("m product", 64'(m_p), 64'(m_exp_q.pop_front()));
            if (m_lat_chk) check("m latency", 64'(m_cyc - ac), 64'd3);
            m_got++;
         end
      end
      m_cyc++;
   endtask

   // randomized instances
   localparam int NRAND = 120;

   for (genvar k = 0; k < 6; k++) begin : g_rand
      localparam int W   = (k / 2 == 0) ? 4 : (k / 2 == 1) ? 8 : 16;
      localparam int OR  = k % 2;
      localparam int LAT = LATENCY[OR];

      logic           rst, iv, ir, sg, ov, ordy;
      logic [W-1:0]   a, b;
      logic [2*W-1:0] p;
      logic [63:0]    exp_q [$];
      int             acc_q [$];
      bit             done = 1'b0;

      dadda_mult_pipe #(.WIDTH(W), .OUT_REG(OR)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (iv),
         .in_ready  (ir),
         .a         (a),
         .b         (b),
         .is_signed (sg),
         .out_valid (ov),
         .out_ready (ordy),
         .product   (p)
      );

      initial begin
         int    sent, cyc, ac;
         bit    ph2;
         string tag;
         tag  = $sformatf("rand w%0d r%0d", W, OR);
         sent = 0; cyc = 0; ph2 = 1'b0;
         rst = 1'b1; iv = 1'b0; a = '0; b = '0; sg = 1'b0; ordy = 1'b1;
         repeat (2) @(negedge clk);
         rst = 1'b0;
         while ((sent < NRAND || exp_q.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            if (sent >= NRAND / 2 && exp_q.size() == 0) ph2 = 1'b1;
            if (!ph2) begin
               iv   = (sent < NRAND / 2);
               ordy = 1'b1;
            end else begin
               iv   = (sent < NRAND) && ($urandom_range(0, 3) != 0);
               ordy = ($urandom_range(0, 4) != 0);
            end
            a  = W'($urandom);
            b  = W'($urandom);
            sg = 1'($urandom_range(0, 1));
            #1;
            if (iv && ir) begin
               exp_q.push_back(ref_mul(32'(a), 32'(b), sg, W));
               acc_q.push_back(ph2 ? -1 : cyc);
               sent++;
            end
            if (ov && ordy) begin
               if (exp_q.size() == 0) begin
                  check({tag, " spurious out_valid"}, 64'(ov), 64'd0);
               end else begin
                  ac = acc_q.pop_front();
                  check({tag, " product"}, 64'(p), exp_q.pop_front());
                  if (ac >= 0) check({tag, " latency"}, 64'(cyc - ac), 64'(LAT));
               end
            end
            cyc++;
         end
         iv = 1'b0;
         check({tag, " sent"}, 64'(sent), 64'(NRAND));
         check({tag, " drained"}, 64'(exp_q.size()), 64'd0);
         done = 1'b1;
      end
   end

   initial begin
      bit          acc;
      int          idx, got0, cidx;
      bit          all_done;
      logic [7:0]  bp_a   [4] = '{8'd3, 8'd200, 8'hF0, 8'h07};
      logic [7:0]  bp_b   [4] = '{8'd5, 8'd100, 8'h10, 8'h81};
      bit          bp_s   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [15:0] bp_exp [4] = '{16'h000F, 16'h4E20, 16'hFF00, 16'hFC87};

      m_rst = 1'b1; m_iv = 1'b0; m_a = '0; m_b = '0; m_sg = 1'b0; m_or = 1'b0;
      m_cycle(0, 8'h00, 8'h00, 0, 0, 1, 16'h0, acc);
      m_cycle(0, 8'h00, 8'h00, 0, 0, 1, 16'h0, acc);
      check("reset out_valid", 64'(m_ov), 64'd0);
      check("reset product", 64'(m_p), 64'd0);

      // directed corner products, out_ready held high
      m_cycle(1, 8'hFF, 8'hFF, 0, 1, 0, 16'hFE01, acc);
      check("in_ready after reset", 64'(m_ir), 64'd1);
      m_cycle(1, 8'h00, 8'hAD, 0, 1, 0, 16'h0000, acc);
      m_cycle(1, 8'h80, 8'h80, 1, 1, 0, 16'h4000, acc);
      m_cycle(1, 8'hFF, 8'h01, 1, 1, 0, 16'hFFFF, acc);
      m_cycle(1, 8'h80, 8'h7F, 1, 1, 0, 16'hC080, acc);
      for (int i = 0; i < 8; i++)
         m_cycle(1, 8'hFF, 8'hFF, 1'(i % 2), 1, 0, (i % 2) ? 16'h0001 : 16'hFE01, acc);
      repeat (5) m_cycle(0, 8'h00, 8'h00, 0, 1, 0, 16'h0, acc);
      check("directed drained", 64'(m_exp_q.size()), 64'd0);
      check("directed count", 64'(m_got), 64'd13);

      // backpressure: out_ready low in cycles 3..7
      m_lat_chk = 1'b0;
      idx  = 0;
      got0 = m_got;
      for (int c = 0; c < 16; c++) begin
         cidx = (idx < 4) ? idx : 0;
         m_cycle(idx < 4, bp_a[cidx], bp_b[cidx], bp_s[cidx], !(c >= 3 && c <= 7), 0,
                 bp_exp[cidx], acc);
         if (acc) idx++;
         if (c >= 3 && c <= 7) begin
            check("bp in_ready", 64'(m_ir), 64'd0);
            check("bp out_valid", 64'(m_ov), 64'd1);
            check("bp product frozen", 64'(m_p), 64'h000F);
         end
      end
      check("bp accepted", 64'(idx), 64'd4);
      check("bp delivered", 64'(m_got - got0), 64'd4);

      // reset with three in flight and the output stalled
      m_cycle(1, 8'h11, 8'h22, 0, 1, 0, 16'h0242, acc);
      m_cycle(1, 8'h05, 8'h06, 0, 1, 0, 16'h001E, acc);
      m_cycle(1, 8'hFE, 8'h03, 1, 1, 0, 16'hFFFA, acc);
      m_cycle(0, 8'h00, 8'h00, 0, 0, 0, 16'h0, acc);
      m_cycle(0, 8'h00, 8'h00, 0, 0, 1, 16'h0, acc);
      m_cycle(0, 8'h00, 8'h00, 0, 1, 0, 16'h0, acc);
      check("rst mid in_ready", 64'(m_ir), 64'd1);
      check("rst mid product", 64'(m_p), 64'd0);
      check("rst mid out_valid c1", 64'(m_ov), 64'd0);
      m_cycle(0, 8'h00, 8'h00, 0, 1, 0, 16'h0, acc);
      check("rst mid out_valid c2", 64'(m_ov), 64'd0);
      m_cycle(0, 8'h00, 8'h00, 0, 1, 0, 16'h0, acc);
      check("rst mid out_valid c3", 64'(m_ov), 64'd0);

      // recovery after reset
      m_lat_chk = 1'b1;
      got0 = m_got;
      m_cycle(1, 8'h0C, 8'h0D, 0, 1, 0, 16'h009C, acc);
      repeat (5) m_cycle(0, 8'h00, 8'h00, 0, 1, 0, 16'h0, acc);
      check("recovery delivered", 64'(m_got - got0), 64'd1);

      all_done = 1'b0;
      for (int c = 0; c < 20000 && !all_done; c++) begin
         @(negedge clk);
         all_done = g_rand[0].done && g_rand[1].done && g_rand[2].done &&
                    g_rand[3].done && g_rand[4].done && g_rand[5].done;
      end
      check("rand streams finished", 64'(all_done), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dadda_mult_pipe.md
DADDA_MULT_PIPE -- requirements
Module: dadda_mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 4..32).
REQ-002 SHALL have parameter OUT_REG, default 1: 1 = registered final adder stage; 0 = final adder combinational into the output register.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, operand pair present.
REQ-006 SHALL have port in_ready, output, 1, block accepts the operand pair this cycle.
REQ-007 SHALL have port a, input, WIDTH, multiplicand.
REQ-008 SHALL have port b, input, WIDTH, multiplier.
REQ-009 SHALL have port is_signed, input, 1: 1 = two's-complement operands; 0 = unsigned operands.
REQ-010 SHALL have port out_valid, output, 1, product present.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the product.
REQ-012 SHALL have port product, output, 2*WIDTH, full-precision result.

Function
REQ-013 SHALL accept a transaction on any cycle where in_valid and in_ready are both 1, and SHALL deliver it on any cycle where out_valid and out_ready are both 1.
REQ-014 SHALL form partial products as a[i] AND b[j]; in signed mode, Baugh-Wooley inversion is applied to MSB-row and MSB-column terms, with constant 1s added at column WIDTH and column 2*WIDTH-1.
REQ-015 SHALL reduce columns with Dadda height sequence 2,3,4,6,9,13,19,28 using full and half adders only, down to two rows, then add the two rows with a 2*WIDTH-bit carry-propagate adder.
REQ-016 SHALL be a three-stage pipeline when OUT_REG=1:
- S1 registers a, b and is_signed.
- S2 registers the two reduced rows.
- S3 registers product.
- Latency is exactly 3 cycles from acceptance to out_valid when no stall occurs.
REQ-017 SHALL be two stages (latency 2) when OUT_REG=0: the CPA is folded into S2, which then drives product.
REQ-018 SHALL carry a valid bit per stage; product and the stage data SHALL be don't-care while the associated valid bit is 0.
REQ-019 SHALL use advance = ~out_valid | out_ready, and in_ready = advance; every stage loads only when advance=1, so the whole pipe freezes on a stall.
REQ-020 SHALL hold product and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL sustain a throughput of one product per cycle when out_ready is held at 1.
REQ-022 SHALL sample is_signed per transaction, allowing signed and unsigned operations to interleave back to back.
REQ-023 SHALL produce results exact modulo 2^(2*WIDTH) with no overflow flag; the full-precision width makes overflow impossible.
REQ-024 SHALL handle simultaneous accept and deliver in the same cycle with no loss or duplication.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, clear all stage valid bits and force out_valid=0 and product=0; data registers other than product need not be reset.
REQ-026 SHALL discard any transactions in flight at reset, including a stalled output, with none ever emitted.
REQ-027 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Structure
REQ-028 SHALL take from shared package dadda_pkg:
- The Dadda height-sequence constant array.
- Function dadda_stage_count(WIDTH).
- Localparam LATENCY(OUT_REG).
REQ-029 SHALL instantiate one combinational sub-module dadda_reduce (parameter WIDTH; inputs: partial-product matrix and is_signed; outputs: two 2*WIDTH rows), generated with generate loops.
REQ-030 SHALL place the CPA and all pipeline control in dadda_mult_pipe.

Verification
REQ-031 SHALL check unsigned correctness (WIDTH=8): 255*255, is_signed=0 -> product 0xFE01 after 3 cycles; 0*173 -> 0x0000.
REQ-032 SHALL check signed corner cases (WIDTH=8, is_signed=1): -128*-128 -> 0x4000; -1*1 -> 0xFFFF; -128*127 -> 0xC080.
REQ-033 SHALL check backpressure: 4 back-to-back inputs, out_ready=0 for cycles 3..7 -> in_ready=0 during the stall, product frozen, all 4 results delivered in order with none lost.
REQ-034 SHALL check reset mid-operation: 3 transactions in flight, rst pulsed for 1 cycle -> out_valid stays 0 for 3 cycles, no stale product appears.
REQ-035 SHALL check mixed mode: alternate is_signed each cycle with a=b=0xFF -> outputs alternate 0xFE01 and 0x0001.
REQ-036 SHALL run randomized back-to-back streams at WIDTH=4, 8 and 16 with OUT_REG=0 and 1, matching a behavioral multiply with latency LATENCY.
